// File: rtl/mem_arbiter.sv
// Arbitrates the single-ported RAM between the icache and dcache miss paths.
// Data-cache block pairs are kept together; icache starvation is bounded by a saturating counter.
module mem_arbiter #(
    parameter int STARVE_MAX = 8,
    parameter int CW         = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, IGNT, DGNT, DHOLD} state_t;

    localparam logic [1:0]    RAM_ACCESS = 2'd2;
    localparam logic [1:0]    RAM_ERROR  = 2'd3;
    localparam logic [CW-1:0] STARVE_LIM = CW'(STARVE_MAX);

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] starve_cnt;
    logic          dreq;
    logic          starved;
    logic          access;

    assign dreq    = dREN || dWEN;
    assign starved = (starve_cnt == STARVE_LIM);
    assign access  = (ramstate == RAM_ACCESS);

    // Both caches see the RAM bus; each samples only on its own completion cycle.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The counter only saturates; preemption is applied solely from IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            starve_cnt <= '0;
            mem_err    <= 1'b0;
        end else begin
            if (!iREN) begin
                starve_cnt <= '0;
            end else if (state == IGNT) begin
                if (access) begin
                    starve_cnt <= '0;
                end
            end else if (!starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if ((state == IGNT || state == DGNT) && ramstate == RAM_ERROR) begin
                mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;

        case (state)
            IDLE: begin
                if (iREN && starved) begin
                    next_state = IGNT;
                end else if (dreq) begin
                    next_state = DGNT;
                end else if (iREN) begin
                    next_state = IGNT;
                end
            end

            IGNT: begin
                if (iREN) begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                end
                if (access) begin
                    iwait      = 1'b0;
                    next_state = IDLE;
                end else if (!iREN) begin
                    next_state = IDLE;
                end
            end

            DGNT: begin
                // A simultaneous read and write is treated as a write.
                if (dreq) begin
                    ramWEN   = dWEN;
                    ramREN   = dREN && !dWEN;
                    ramaddr  = daddr;
                    ramstore = dstore;
                end
                if (access) begin
                    dwait      = 1'b0;
                    next_state = daddr[2] ? IDLE : DHOLD;
                end else if (!dreq) begin
                    next_state = IDLE;
                end
            end

            DHOLD: begin
                next_state = (dreq && daddr[2]) ? DGNT : IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected completions,
// a negedge monitor pops and compares them whenever a wait line drops.
module tb_mem_arbiter;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    logic        mem_err;

    localparam logic [1:0] FREE   = 2'd0;
    localparam logic [1:0] BUSY   = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] ERROR  = 2'd3;

    typedef struct {
        logic        isD;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } expect_t;

    expect_t scoreboard[$];
    int      checks = 0;
    int      errors = 0;

    mem_arbiter #(.STARVE_MAX(8), .CW(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .mem_err(mem_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic nextCycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic applyStimulus(input logic ir, input logic [31:0] ia, input logic dr,
                                 input logic dw, input logic [31:0] da, input logic [31:0] ds,
                                 input logic [1:0] rs, input logic [31:0] rl);
        iREN = ir; iaddr = ia; dREN = dr; dWEN = dw;
        daddr = da; dstore = ds; ramstate = rs; ramload = rl;
    endtask

    task automatic expectDone(input logic isD, input logic wr, input logic [31:0] a, input logic [31:0] d);
        expect_t e;
        e.isD = isD; e.wr = wr; e.addr = a; e.data = d;
        scoreboard.push_back(e);
    endtask

    // Two-word dcache write block starting in IDLE; leaves dWEN asserted.
    task automatic writeBlock(input logic ir, input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1);
        applyStimulus(ir, 32'h44, 1'b0, 1'b1, base, d0, FREE, 32'h0);
        nextCycle();
        ramstate = ACCESS;
        expectDone(1'b1, 1'b1, base, d0);
        nextCycle();
        daddr = base + 32'd4; dstore = d1; ramstate = FREE;
        @(negedge CLK);
        checkOutput("dholdNoWrite", {31'b0, ramWEN}, 32'd0);
        nextCycle();
        ramstate = ACCESS;
        expectDone(1'b1, 1'b1, base + 32'd4, d1);
        nextCycle();
        ramstate = FREE;
    endtask

    always @(negedge CLK) begin
        if (!RST && (!iwait || !dwait)) begin
            if (!iwait && !dwait) begin
                checks++; errors++;
                $display("[TB] FAIL bothWaitLow got iwait=%b dwait=%b expected one high", iwait, dwait);
            end else if (scoreboard.size() == 0) begin
                checks++; errors++;
                $display("[TB] FAIL unexpectedCompletion got iwait=%b dwait=%b expected none", iwait, dwait);
            end else begin
                expect_t e;
                e = scoreboard.pop_front();
                checkOutput("completionPort", {31'b0, !dwait}, {31'b0, e.isD});
                checkOutput("completionAddr", ramaddr, e.addr);
                if (e.wr) begin
                    checkOutput("completionWEN", {31'b0, ramWEN}, 32'd1);
                    checkOutput("completionStore", ramstore, e.data);
                end else begin
                    checkOutput("completionREN", {31'b0, ramREN}, 32'd1);
                    checkOutput("completionLoad", e.isD ? dload : iload, e.data);
                end
            end
        end
    end

    initial begin
        RST = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        @(negedge CLK);
        checkOutput("rstRamREN", {31'b0, ramREN}, 32'd0);
        checkOutput("rstRamWEN", {31'b0, ramWEN}, 32'd0);
        checkOutput("rstRamAddr", ramaddr, 32'd0);
        checkOutput("rstWaits", {30'b0, iwait, dwait}, 32'd3);
        checkOutput("rstMemErr", {31'b0, mem_err}, 32'd0);
        nextCycle();
        RST = 1'b0;

        // Reset in the middle of a busy dcache write grant
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h300, 32'hCAFE0000, BUSY, 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("preRstWEN", {31'b0, ramWEN}, 32'd1);
        #1 RST = 1'b1;
        #2;
        checkOutput("midRstWEN", {31'b0, ramWEN}, 32'd0);
        checkOutput("midRstREN", {31'b0, ramREN}, 32'd0);
        checkOutput("midRstWaits", {30'b0, iwait, dwait}, 32'd3);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        nextCycle();
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("postRstMemErr", {31'b0, mem_err}, 32'd0);
        checkOutput("postRstAddr", ramaddr, 32'd0);

        // Lone icache read with two busy cycles
        nextCycle();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, BUSY, 32'h0);
        @(negedge CLK);
        checkOutput("iIdleNoREN", {31'b0, ramREN}, 32'd0);
        nextCycle();
        @(negedge CLK);
        checkOutput("iGrantREN", {31'b0, ramREN}, 32'd1);
        checkOutput("iGrantAddr", ramaddr, 32'h40);
        checkOutput("iBusyWait", {31'b0, iwait}, 32'd1);
        nextCycle();
        @(negedge CLK);
        checkOutput("iBusyWait2", {31'b0, iwait}, 32'd1);
        nextCycle();
        ramstate = ACCESS; ramload = 32'hDEADBEEF;
        expectDone(1'b0, 1'b0, 32'h40, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Simultaneous requests: dcache block first, then icache
        applyStimulus(1'b1, 32'h80, 1'b1, 1'b0, 32'h100, 32'h0, FREE, 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("dWinsAddr", ramaddr, 32'h100);
        checkOutput("dWinsREN", {31'b0, ramREN}, 32'd1);
        ramstate = ACCESS; ramload = 32'hAAAA0001;
        expectDone(1'b1, 1'b0, 32'h100, 32'hAAAA0001);
        nextCycle();
        daddr = 32'h104; ramstate = FREE;
        @(negedge CLK);
        checkOutput("dholdNoREN", {31'b0, ramREN}, 32'd0);
        nextCycle();
        @(negedge CLK);
        checkOutput("secondWordAddr", ramaddr, 32'h104);
        ramstate = ACCESS; ramload = 32'hAAAA0002;
        expectDone(1'b1, 1'b0, 32'h104, 32'hAAAA0002);
        nextCycle();
        dREN = 1'b0; ramstate = FREE;
        nextCycle();
        @(negedge CLK);
        checkOutput("iAfterBlockAddr", ramaddr, 32'h80);
        ramstate = ACCESS; ramload = 32'hBBBB0000;
        expectDone(1'b0, 1'b0, 32'h80, 32'hBBBB0000);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);

        // Write beats read when both are raised
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h200, 32'h12345678, FREE, 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("bothWEN", {31'b0, ramWEN}, 32'd1);
        checkOutput("bothREN", {31'b0, ramREN}, 32'd0);
        checkOutput("bothStore", ramstore, 32'h12345678);
        ramstate = ACCESS;
        expectDone(1'b1, 1'b1, 32'h200, 32'h12345678);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        nextCycle();
        @(negedge CLK);
        checkOutput("idleStoreZero", ramstore, 32'h0);

        // Starvation: two write blocks with iREN held, then forced icache grant
        writeBlock(1'b1, 32'h300, 32'h11110000, 32'h11110001);
        writeBlock(1'b1, 32'h308, 32'h22220000, 32'h22220001);
        @(negedge CLK);
        checkOutput("starveSaturated", 32'(dut.starve_cnt), 32'd8);
        nextCycle();
        @(negedge CLK);
        checkOutput("starveIGrantREN", {31'b0, ramREN}, 32'd1);
        checkOutput("starveIGrantWEN", {31'b0, ramWEN}, 32'd0);
        checkOutput("starveIGrantAddr", ramaddr, 32'h44);
        ramstate = ACCESS; ramload = 32'h5A5A5A5A;
        expectDone(1'b0, 1'b0, 32'h44, 32'h5A5A5A5A);
        nextCycle();
        ramstate = FREE;
        @(negedge CLK);
        checkOutput("starveCleared", 32'(dut.starve_cnt), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        nextCycle();
        nextCycle();

        // ERROR during an icache grant sets the sticky flag
        checkOutput("preErrMemErr", {31'b0, mem_err}, 32'd0);
        applyStimulus(1'b1, 32'h60, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        nextCycle();
        ramstate = ERROR;
        @(negedge CLK);
        checkOutput("errWait", {31'b0, iwait}, 32'd1);
        nextCycle();
        @(negedge CLK);
        checkOutput("errMemErrSet", {31'b0, mem_err}, 32'd1);
        checkOutput("errHoldAddr", ramaddr, 32'h60);
        ramstate = ACCESS; ramload = 32'h0BADF00D;
        expectDone(1'b0, 1'b0, 32'h60, 32'h0BADF00D);
        nextCycle();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0);
        nextCycle();
        nextCycle();
        @(negedge CLK);
        checkOutput("errMemErrSticky", {31'b0, mem_err}, 32'd1);
        checkOutput("scoreboardEmpty", 32'(scoreboard.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single-ported RAM between the instruction cache and the data cache.
- Grants one requester at a time and holds the grant across the two-word data block transfer so the pair is not interleaved with instruction fetches.
- Bounds instruction-fetch starvation with a saturating wait counter.
- Sits between the icache/dcache miss paths and the RAM model, replacing direct cache-to-RAM wiring.

Parameters:
- STARVE_MAX, 8: consecutive cycles iREN may wait ungranted before the icache is forced ahead of the dcache.
- CW, 4: starvation counter width; must hold STARVE_MAX.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle the icache word completes.
- iload  out  32  icache read data.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request.
- daddr  in  32  dcache word address; bit 2 selects the block word.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache word completes.
- dload  out  32  dcache read data.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS (word done this cycle), 3 ERROR.
- mem_err  out  1  sticky; set when ramstate==ERROR during a grant.

Behaviour:
- Reset (async, RST=1):
  - state=IDLE, starve_cnt=0, mem_err=0.
  - Outputs: ramREN/ramWEN/ramaddr/ramstore=0; iwait=dwait=1.
  - A transfer in flight is abandoned with no completion pulse.
- States: IDLE, IGNT, DGNT, DHOLD.
- IDLE: no RAM strobes. Selection, in priority order:
  - iREN && starve_cnt==STARVE_MAX -> IGNT.
  - else (dREN||dWEN) -> DGNT.
  - else iREN -> IGNT.
  - else stay IDLE.
- Grant latency: a request first seen in IDLE at cycle N is driven to RAM from cycle N+1.
- IGNT:
  - ramREN=iREN; ramaddr=iaddr.
  - ramstate==ACCESS: iwait=0 that cycle -> IDLE.
  - iREN dropped: no strobes that cycle -> IDLE.
- DGNT:
  - ramWEN=dWEN; ramREN=dREN && !dWEN (write wins if both asserted).
  - ramaddr=daddr; ramstore=dstore.
  - On ACCESS: dwait=0. If daddr[2]==0 -> DHOLD, else -> IDLE.
  - Request dropped: -> IDLE.
- DHOLD (one cycle, no strobes):
  - (dREN||dWEN) && daddr[2]==1 -> DGNT, bypassing the IDLE starvation check.
  - otherwise -> IDLE.
- Completion pulses:
  - iwait/dwait are combinational from (state, ramstate).
  - Never low outside the owner's grant state; never both low in one cycle.
- Data paths:
  - iload=ramload and dload=ramload at all times; consumers sample only on their own completion cycle.
- Strobe rules:
  - The non-owner's request lines never reach RAM.
  - ramaddr/ramstore are 0 whenever no strobe is asserted.
- ramstate handling during a grant:
  - BUSY or FREE: hold state; wait stays high.
  - ERROR: hold state; wait stays high; mem_err <= 1 until reset.
- starve_cnt:
  - +1 each cycle iREN=1 and state!=IGNT, saturating at STARVE_MAX.
  - Cleared on the IGNT completion cycle, or when iREN=0.
  - Saturation while in DGNT/DHOLD does not preempt; it takes effect at the next IDLE.
- Simultaneous iREN and dREN in IDLE with starve_cnt<STARVE_MAX: the dcache wins.
- An owner deasserting its request on its ACCESS cycle is a normal completion.

Test Plan:
- Reset mid-DGNT with ramstate=BUSY -> next cycle ramWEN=ramREN=0, dwait=iwait=1, state IDLE, mem_err=0.
- iREN alone, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN high from cycle 1; iwait=0 only on the ACCESS cycle; iload=0xDEADBEEF.
- iREN and dREN together at daddr=0x100, then 0x104 -> dcache served first. DHOLD carries directly into the second word with no icache grant between. IGNT follows afterwards.
- dWEN and dREN both high, daddr=0x200, dstore=0x12345678 -> ramWEN=1, ramREN=0, ramstore=0x12345678.
- Back-to-back dcache block writes with iREN held continuously, STARVE_MAX=8 -> starve_cnt reaches 8. The next IDLE grants the icache even with a dcache request pending, and the counter clears on icache completion.
- ramstate=ERROR for 1 cycle during IGNT, then ACCESS -> mem_err=1 and stays 1; iwait low only on the ACCESS cycle.
